// File: rtl/sram_like_arbiter_if.sv
// Bundle of the N master-side SRAM-like channels plus the single downstream
// SRAM-like port that the arbiter merges them onto.
interface sram_like_arbiter_if #(
    parameter int NUM_CH = 2
) ();

    // Master-side channels, channel i occupies slice i of each vector
    logic [NUM_CH-1:0]    m_req;
    logic [NUM_CH-1:0]    m_wr;
    logic [2*NUM_CH-1:0]  m_size;
    logic [4*NUM_CH-1:0]  m_wstrb;
    logic [32*NUM_CH-1:0] m_addr;
    logic [32*NUM_CH-1:0] m_wdata;
    logic [NUM_CH-1:0]    m_addr_ok;
    logic [NUM_CH-1:0]    m_data_ok;
    logic [31:0]          m_rdata;

    // Downstream port
    logic                 s_req;
    logic                 s_wr;
    logic [1:0]           s_size;
    logic [3:0]           s_wstrb;
    logic [31:0]          s_addr;
    logic [31:0]          s_wdata;
    logic                 s_addr_ok;
    logic                 s_data_ok;
    logic [31:0]          s_rdata;

    // Arbiter view: receives master requests and downstream handshakes
    modport slave (
        input  m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
        input  s_addr_ok, s_data_ok, s_rdata,
        output m_addr_ok, m_data_ok, m_rdata,
        output s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata
    );

    // Environment view: CPU masters and the memory bridge together
    modport master (
        output m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
        output s_addr_ok, s_data_ok, s_rdata,
        input  m_addr_ok, m_data_ok, m_rdata,
        input  s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata
    );

endinterface

// File: rtl/sram_like_arbiter.sv
// N-channel fixed-priority (highest index wins) arbiter merging SRAM-like
// masters onto one downstream port. A stalled grant is locked until the
// downstream accepts it; accepted channel IDs are kept in an in-order queue
// so each downstream data_ok is routed back to the channel that issued it.
module sram_like_arbiter #(
    parameter int NUM_CH    = 2,
    parameter int OUT_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    sram_like_arbiter_if.slave           bus,
    output logic [$clog2(OUT_DEPTH):0]   outstanding,
    output logic                         proto_err
);

    localparam int ID_W  = $clog2(NUM_CH);
    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Lock and ID queue state
    logic                lock_valid_r;
    logic [ID_W-1:0]     lock_id_r;
    logic [ID_W-1:0]     queue_r [OUT_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_W-1:0]    outstanding_r;
    logic                proto_err_r;

    // Combinational arbitration and routing
    logic [ID_W-1:0]     high_id_s;
    logic                lock_hold_s;
    logic [ID_W-1:0]     grant_s;
    logic                s_req_s;
    logic                accept_s;
    logic                pop_s;
    logic                spurious_s;
    logic [ID_W-1:0]     head_id_s;
    logic                s_wr_s;
    logic [1:0]          s_size_s;
    logic [3:0]          s_wstrb_s;
    logic [31:0]         s_addr_s;
    logic [31:0]         s_wdata_s;
    logic [NUM_CH-1:0]   addr_ok_s;
    logic [NUM_CH-1:0]   data_ok_s;

    // Highest-index requesting channel; the last match in the scan wins
    always_comb begin
        high_id_s = {ID_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            high_id_s = bus.m_req[i] ? ID_W'(i) : high_id_s;
        end
    end

    // A lock only counts while its owner still requests; a dropped request
    // falls back to normal priority in the same cycle.
    assign lock_hold_s = lock_valid_r & bus.m_req[lock_id_r];
    assign grant_s     = lock_hold_s ? lock_id_r : high_id_s;

    // A full queue masks the request even if a pop happens this cycle
    assign s_req_s    = (|bus.m_req) & (outstanding_r < CNT_W'(OUT_DEPTH));
    assign accept_s   = s_req_s & bus.s_addr_ok;
    assign pop_s      = bus.s_data_ok & (outstanding_r != {CNT_W{1'b0}});
    assign spurious_s = bus.s_data_ok & (outstanding_r == {CNT_W{1'b0}});
    assign head_id_s  = queue_r[rd_ptr_r];

    // AND-OR mux of the granted channel onto the downstream port, zero when idle
    always_comb begin
        s_wr_s    = 1'b0;
        s_size_s  = 2'b00;
        s_wstrb_s = 4'h0;
        s_addr_s  = 32'h0000_0000;
        s_wdata_s = 32'h0000_0000;
        for (int i = 0; i < NUM_CH; i++) begin
            s_wr_s    = s_wr_s    | (s_req_s & (grant_s == ID_W'(i)) & bus.m_wr[i]);
            s_size_s  = s_size_s  | ({2{s_req_s & (grant_s == ID_W'(i))}}  & bus.m_size[2*i +: 2]);
            s_wstrb_s = s_wstrb_s | ({4{s_req_s & (grant_s == ID_W'(i))}}  & bus.m_wstrb[4*i +: 4]);
            s_addr_s  = s_addr_s  | ({32{s_req_s & (grant_s == ID_W'(i))}} & bus.m_addr[32*i +: 32]);
            s_wdata_s = s_wdata_s | ({32{s_req_s & (grant_s == ID_W'(i))}} & bus.m_wdata[32*i +: 32]);
        end
    end

    // One-hot accept to the granted channel and response to the queue head
    always_comb begin
        addr_ok_s = {NUM_CH{1'b0}};
        data_ok_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            addr_ok_s[i] = accept_s & (grant_s == ID_W'(i));
            data_ok_s[i] = pop_s & (head_id_s == ID_W'(i));
        end
    end

    assign bus.s_req     = s_req_s;
    assign bus.s_wr      = s_wr_s;
    assign bus.s_size    = s_size_s;
    assign bus.s_wstrb   = s_wstrb_s;
    assign bus.s_addr    = s_addr_s;
    assign bus.s_wdata   = s_wdata_s;
    assign bus.m_addr_ok = addr_ok_s;
    assign bus.m_data_ok = data_ok_s;
    assign bus.m_rdata   = {32{pop_s}} & bus.s_rdata;
    assign outstanding   = outstanding_r;
    assign proto_err     = proto_err_r;

    // Grant lock: hold a stalled downstream request until it is accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_valid_r <= 1'b0;
            lock_id_r    <= {ID_W{1'b0}};
        end else if (s_req_s) begin
            lock_valid_r <= ~bus.s_addr_ok;
            lock_id_r    <= grant_s;
        end else begin
            lock_valid_r <= lock_hold_s;
            lock_id_r    <= lock_id_r;
        end
    end

    // ID queue write side: record the channel of every accepted request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            for (int k = 0; k < OUT_DEPTH; k++) begin
                queue_r[k] <= {ID_W{1'b0}};
            end
        end else if (accept_s) begin
            queue_r[wr_ptr_r] <= grant_s;
            wr_ptr_r          <= wr_ptr_r + PTR_W'(1);
        end
    end

    // ID queue read side: advance past the head on each routed response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_r <= {PTR_W{1'b0}};
        end else if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        end
    end

    // Occupancy counter; simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding_r <= {CNT_W{1'b0}};
        end else begin
            case ({accept_s, pop_s})
                2'b10:   outstanding_r <= outstanding_r + CNT_W'(1);
                2'b01:   outstanding_r <= outstanding_r - CNT_W'(1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Sticky flag for a downstream response with nothing outstanding
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            proto_err_r <= 1'b0;
        end else begin
            proto_err_r <= proto_err_r | spurious_s;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter (2 channels, depth 4). Expected accepts
// and responses are queued by the stimulus; a monitor compares them whenever
// the DUT raises m_addr_ok / m_data_ok.
module tb_sram_like_arbiter;

    logic       clk;
    logic       reset;
    logic [2:0] outstanding;
    logic       proto_err;

    typedef struct packed {
        logic [1:0]  ch;
        logic [31:0] data;
    } resp_t;

    logic [1:0] exp_acc [$];
    resp_t      exp_resp [$];
    int         checks;
    int         errors;

    sram_like_arbiter_if #(.NUM_CH(2)) bus ();

    sram_like_arbiter #(.NUM_CH(2), .OUT_DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .outstanding (outstanding),
        .proto_err   (proto_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] req, input logic aok, input logic dok, input logic [31:0] rdata);
        bus.m_req     = req;
        bus.s_addr_ok = aok;
        bus.s_data_ok = dok;
        bus.s_rdata   = rdata;
    endtask

    task automatic idle();
        drive(2'b00, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic exp_r(input logic [1:0] ch, input logic [31:0] data);
        resp_t r;
        r.ch   = ch;
        r.data = data;
        exp_resp.push_back(r);
    endtask

    // Monitor: consume an expectation whenever the DUT signals accept/response
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.m_addr_ok != 2'b00) begin
                    if (exp_acc.size() == 0) begin
                        chk("acc_unexpected", 32'(bus.m_addr_ok), 32'h0);
                    end else begin
                        logic [1:0] e;
                        e = exp_acc.pop_front();
                        chk("acc_channel", 32'(bus.m_addr_ok), 32'(e));
                    end
                end
                if (bus.m_data_ok != 2'b00) begin
                    if (exp_resp.size() == 0) begin
                        chk("resp_unexpected", 32'(bus.m_data_ok), 32'h0);
                    end else begin
                        resp_t r;
                        r = exp_resp.pop_front();
                        chk("resp_channel", 32'(bus.m_data_ok), 32'(r.ch));
                        chk("resp_data", bus.m_rdata, r.data);
                    end
                end
            end
        end
    end

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        bus.m_wr    = 2'b00;
        bus.m_size  = 4'h0;
        bus.m_wstrb = 8'h00;
        bus.m_addr  = 64'h0;
        bus.m_wdata = 64'h0;
        idle();

        // Reset state
        #12;
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
        chk("rst_s_req", 32'(bus.s_req), 32'd0);
        chk("rst_m_addr_ok", 32'(bus.m_addr_ok), 32'd0);
        chk("rst_m_data_ok", 32'(bus.m_data_ok), 32'd0);
        chk("rst_m_rdata", bus.m_rdata, 32'd0);
        reset = 1'b0;
        tick();

        // Single channel-0 read
        bus.m_addr = {32'h0, 32'h1C00_0000};
        drive(2'b01, 1'b1, 1'b0, 32'h0);
        exp_acc.push_back(2'b01);
        #2;
        chk("t1_s_req", 32'(bus.s_req), 32'd1);
        chk("t1_s_addr", bus.s_addr, 32'h1C00_0000);
        tick();
        idle();
        #2 chk("t1_outstanding_1", 32'(outstanding), 32'd1);
        tick();
        tick();
        drive(2'b00, 1'b0, 1'b1, 32'h1234_5678);
        exp_r(2'b01, 32'h1234_5678);
        tick();
        idle();
        #2 chk("t1_outstanding_0", 32'(outstanding), 32'd0);
        tick();

        // Priority and lock: ch0 stalls, ch1 arrives but cannot preempt
        bus.m_addr = {32'h0000_0200, 32'h0000_0100};
        drive(2'b01, 1'b0, 1'b0, 32'h0);
        #2 chk("lock_a_addr", bus.s_addr, 32'h100);
        tick();
        #2 chk("lock_b_addr", bus.s_addr, 32'h100);
        tick();
        drive(2'b11, 1'b0, 1'b0, 32'h0);
        #2 chk("lock_c_addr", bus.s_addr, 32'h100);
        tick();
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        exp_acc.push_back(2'b01);
        #2 chk("lock_d_addr", bus.s_addr, 32'h100);
        tick();
        exp_acc.push_back(2'b10);
        #2 chk("lock_e_addr", bus.s_addr, 32'h200);
        tick();
        idle();
        #2 chk("lock_outstanding", 32'(outstanding), 32'd2);

        // Simultaneous push and pop at occupancy 2 (queue: ch0, ch1)
        bus.m_addr = {32'h0000_0200, 32'h0000_0300};
        drive(2'b01, 1'b1, 1'b1, 32'hAAAA_0001);
        exp_acc.push_back(2'b01);
        exp_r(2'b01, 32'hAAAA_0001);
        tick();
        idle();
        #2 chk("pushpop_outstanding", 32'(outstanding), 32'd2);
        drive(2'b00, 1'b0, 1'b1, 32'hBBBB_0002);
        exp_r(2'b10, 32'hBBBB_0002);
        tick();
        drive(2'b00, 1'b0, 1'b1, 32'hCCCC_0003);
        exp_r(2'b01, 32'hCCCC_0003);
        tick();
        idle();
        #2 chk("pushpop_drained", 32'(outstanding), 32'd0);

        // Ordering: accept ch1, ch0, ch1 then three responses
        drive(2'b10, 1'b1, 1'b0, 32'h0); exp_acc.push_back(2'b10); tick();
        drive(2'b01, 1'b1, 1'b0, 32'h0); exp_acc.push_back(2'b01); tick();
        drive(2'b10, 1'b1, 1'b0, 32'h0); exp_acc.push_back(2'b10); tick();
        idle();
        #2 chk("order_outstanding_3", 32'(outstanding), 32'd3);
        drive(2'b00, 1'b0, 1'b1, 32'h11); exp_r(2'b10, 32'h11); tick();
        drive(2'b00, 1'b0, 1'b1, 32'h22); exp_r(2'b01, 32'h22); tick();
        drive(2'b00, 1'b0, 1'b1, 32'h33); exp_r(2'b10, 32'h33); tick();
        idle();
        #2 chk("order_outstanding_0", 32'(outstanding), 32'd0);

        // Full queue with pointer wrap, then no fall-through on pop
        bus.m_addr  = {32'h0000_0500, 32'h0000_0400};
        bus.m_wr    = 2'b10;
        bus.m_size  = {2'd2, 2'd0};
        bus.m_wstrb = {4'hF, 4'h1};
        bus.m_wdata = {32'hCAFE_F00D, 32'h0};
        drive(2'b01, 1'b1, 1'b0, 32'h0); exp_acc.push_back(2'b01); tick();
        drive(2'b10, 1'b1, 1'b0, 32'h0); exp_acc.push_back(2'b10); tick();
        drive(2'b01, 1'b1, 1'b0, 32'h0); exp_acc.push_back(2'b01); tick();
        drive(2'b10, 1'b1, 1'b0, 32'h0); exp_acc.push_back(2'b10); tick();
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        #2;
        chk("full_outstanding", 32'(outstanding), 32'd4);
        chk("full_s_req", 32'(bus.s_req), 32'd0);
        chk("full_s_addr_zero", bus.s_addr, 32'd0);
        chk("full_s_wr_zero", 32'(bus.s_wr), 32'd0);
        tick();
        drive(2'b11, 1'b1, 1'b1, 32'hD000_0001);
        exp_r(2'b01, 32'hD000_0001);
        #2 chk("full_pop_s_req", 32'(bus.s_req), 32'd0);
        tick();
        drive(2'b11, 1'b0, 1'b0, 32'h0);
        #2;
        chk("full_after_pop_outstanding", 32'(outstanding), 32'd3);
        chk("full_after_pop_s_req", 32'(bus.s_req), 32'd1);
        chk("mux_s_addr", bus.s_addr, 32'h500);
        chk("mux_s_wr", 32'(bus.s_wr), 32'd1);
        chk("mux_s_size", 32'(bus.s_size), 32'd2);
        chk("mux_s_wstrb", 32'(bus.s_wstrb), 32'hF);
        chk("mux_s_wdata", bus.s_wdata, 32'hCAFE_F00D);
        tick();
        drive(2'b00, 1'b0, 1'b1, 32'hD000_0002); exp_r(2'b10, 32'hD000_0002); tick();
        drive(2'b00, 1'b0, 1'b1, 32'hD000_0003); exp_r(2'b01, 32'hD000_0003); tick();
        drive(2'b00, 1'b0, 1'b1, 32'hD000_0004); exp_r(2'b10, 32'hD000_0004); tick();
        idle();
        #2 chk("full_drained", 32'(outstanding), 32'd0);

        // Spurious response sets sticky proto_err; async reset clears it
        drive(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF);
        #2 chk("spur_no_data_ok", 32'(bus.m_data_ok), 32'd0);
        tick();
        idle();
        #2 chk("spur_proto_err", 32'(proto_err), 32'd1);
        tick();
        tick();
        #1 chk("spur_proto_err_sticky", 32'(proto_err), 32'd1);
        #1 reset = 1'b1;
        #1 chk("async_rst_proto_err", 32'(proto_err), 32'd0);
        #2 reset = 1'b0;
        tick();

        // Reset mid-transfer: a later response to the lost request is spurious
        drive(2'b10, 1'b1, 1'b0, 32'h0);
        exp_acc.push_back(2'b10);
        tick();
        idle();
        #1 chk("mid_outstanding_1", 32'(outstanding), 32'd1);
        #1 reset = 1'b1;
        #1 chk("mid_rst_outstanding", 32'(outstanding), 32'd0);
        #2 reset = 1'b0;
        tick();
        drive(2'b00, 1'b0, 1'b1, 32'h0000_0055);
        #2 chk("mid_no_data_ok", 32'(bus.m_data_ok), 32'd0);
        tick();
        idle();
        #2 chk("mid_proto_err", 32'(proto_err), 32'd1);
        tick();

        chk("acc_queue_empty", 32'(exp_acc.size()), 32'd0);
        chk("resp_queue_empty", 32'(exp_resp.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Parametrised N-channel arbiter that merges the CPU's SRAM-like request/response channels onto a single downstream SRAM-like port. Each channel uses the req/addr_ok/data_ok handshake. The arbiter grants one channel per cycle using fixed priority, with the highest index winning. A grant is held stable until the downstream port accepts it. Every accepted request's channel ID is recorded in an in-order outstanding queue, and each downstream data_ok is returned to the correct channel. The block sits between the mycpu_top instruction/data ports and the memory bridge, so instruction fetch and load/store can share one bus with several requests in flight.

## Interface
Parameters:
- NUM_CH, 2: number of master channels; channel 0 = inst, highest = data by convention; valid range 2..8.
- OUT_DEPTH, 4: maximum number of outstanding (accepted, not yet data_ok) requests; power of two, ≥2.
- ID_W (localparam): clog2(NUM_CH).

Ports (clock is single; reset is asynchronous and active-high):
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- m_req  in  NUM_CH  per-channel request.
- m_wr  in  NUM_CH  per-channel write flag.
- m_size  in  2*NUM_CH  per-channel size (0=byte, 1=half, 2=word); channel i at [2i+1:2i].
- m_wstrb  in  4*NUM_CH  per-channel byte strobes.
- m_addr  in  32*NUM_CH  per-channel address.
- m_wdata  in  32*NUM_CH  per-channel write data.
- m_addr_ok  out  NUM_CH  request accepted this cycle (one-hot or zero).
- m_data_ok  out  NUM_CH  response for the channel this cycle (one-hot or zero).
- m_rdata  out  32  read data broadcast to all channels; meaningful only where m_data_ok is set.
- s_req / s_wr  out  1 each  downstream request and write flag.
- s_size  out  2  downstream size.
- s_wstrb  out  4  downstream byte strobes.
- s_addr / s_wdata  out  32 each  downstream address and write data.
- s_addr_ok / s_data_ok  in  1 each  downstream handshake.
- s_rdata  in  32  downstream read data.
- outstanding  out  clog2(OUT_DEPTH)+1  current queue occupancy.
- proto_err  out  1  sticky flag: s_data_ok arrived with an empty queue.

## Operation
- Grant selection:
  - When unlocked, grant = highest index i with m_req[i]=1.
  - When locked, grant = lock_id.
- s_req = (any m_req) & (outstanding < OUT_DEPTH).
- s_wr/s_size/s_wstrb/s_addr/s_wdata are muxed from the granted channel. When s_req=0 they are driven to 0.
- Accept: when s_req & s_addr_ok, set m_addr_ok[grant]=1, push grant into the ID queue, and clear the lock.
- Lock: when s_req & ~s_addr_ok, set lock_valid=1 and lock_id=grant at the next edge. This holds the downstream request stable; a higher-priority arrival cannot preempt it.
- Locked channel drops m_req (master protocol violation): lock clears at the next edge; that cycle s_req follows the normal priority among the remaining requests.
- Response: when s_data_ok & queue non-empty, set m_data_ok[head]=1, m_rdata=s_rdata, and pop the queue.
- s_data_ok with an empty queue: no pop, all m_data_ok=0, proto_err set to 1 until reset.
- Push and pop in the same cycle: occupancy is unchanged and both take effect.
- Full queue: s_req is masked even if a pop occurs the same cycle; no fall-through.
- Queue: circular buffer of OUT_DEPTH × ID_W entries. Read/write pointers are log2(OUT_DEPTH) bits and wrap naturally. Occupancy counter is separate.

## Timing
- Reset values: lock_valid=0, pointers=0, outstanding=0, proto_err=0. All combinational outputs are 0 whenever every m_req=0 and s_data_ok=0.
- Request path is combinational: m_req → s_req → s_addr_ok → m_addr_ok in the same cycle, zero added latency.
- Response path is combinational: s_data_ok → m_data_ok in the same cycle.
- Response order equals acceptance order across all channels.
- outstanding and proto_err are registered and update one edge after the triggering event.
- Reset mid-transfer clears the queue immediately. Downstream responses to requests accepted before reset set proto_err.

## Test plan
- Single channel 0 read: m_req[0]=1, addr 0x1C000000, s_addr_ok=1 same cycle → m_addr_ok=2'b01, outstanding=1. Two cycles later s_data_ok=1, s_rdata=0x12345678 → m_data_ok=2'b01, m_rdata=0x12345678, outstanding=0.
- Priority plus lock: m_req=2'b01 with s_addr_ok=0 for 2 cycles, then m_req=2'b11 → s_addr stays at channel 0's address until s_addr_ok. Channel 1 is granted on the following cycle.
- Ordering: accept in order ch1, ch0, ch1, then three s_data_ok pulses → m_data_ok sequence 10, 01, 10.
- Full queue: OUT_DEPTH=4, accept 4 without responses → s_req=0 with m_req held. Next cycle s_data_ok pop → outstanding=3 and s_req=1; wrap-around verified over 10 transactions.
- Simultaneous push/pop at outstanding=2 → outstanding remains 2, correct head routing.
- Spurious response: s_data_ok=1 with empty queue → no m_data_ok, proto_err=1 and stays 1. Asynchronous reset mid-cycle clears it immediately.
